audio_frame_scheduler: RTL
==========================

Name: audio_frame_scheduler

Overview:
Sequences capture-and-analyse frames on the audio sample RAM. Each frame it fires a one-cycle load request to the RAM write controller and waits for load-complete. It then streams all 2^LBITS stored samples, in address order, to the FFT input with a valid/ready handshake, and waits for FFT done. It sits between the top-level game control and the audio RAM / FFT pair, and paces frames with a programmable hold-off interval.

Parameters:
BITS, 16, sample width
LBITS, 10, RAM address width; frame length N = 2^LBITS
HOLDOFF_CYC, 50000, idle cycles between end of one frame and the next load request
LOAD_TIMEOUT, 2000000, max cycles to wait for load-complete before abort

Ports:
iClock  in  1  system clock; RAM read port and FFT share it
iReset  in  1  reset, asynchronous, active-high
iEnable  in  1  run frames continuously while high
iWindowSel  in  1  window choice, 1 = Hann, 0 = Hamming
iLoadComplete  in  1  level from RAM write controller, high when frame stored
iRamData  in  BITS  RAM read data; valid one cycle after oReadAddr issued
iFftReady  in  1  FFT accepts a sample this cycle
iFftDone  in  1  one-cycle pulse, FFT finished frame
oStartLoad  out  1  one-cycle load request pulse
oWindow  out  1  window select, latched per frame
oReadAddr  out  LBITS  RAM read address
oSample  out  BITS  sample to FFT
oValid  out  1  oSample valid
oSop  out  1  first sample of frame (qualified by oValid)
oEop  out  1  last sample of frame (qualified by oValid)
oBusy  out  1  high in any state except IDLE
oFrameCount  out  8  completed frames, wraps 255->0
oLoadTimeout  out  1  sticky abort flag, cleared on next oStartLoad

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Reset asserted mid-frame aborts immediately. No pending transfer survives reset.
- States: IDLE, LOAD, WAITLOAD, STREAM, WAITFFT, HOLDOFF.
- IDLE: when iEnable=1, go to LOAD.
- LOAD (1 cycle): oStartLoad=1, oWindow<=iWindowSel, timeout counter cleared, oLoadTimeout<=0. Next state WAITLOAD.
- WAITLOAD: ignore iLoadComplete in the first cycle, because a stale high level from the previous frame may still be present. From the second cycle, iLoadComplete=1 moves to STREAM. If the counter reaches LOAD_TIMEOUT first, set oLoadTimeout=1 and go to IDLE.
- STREAM, read pipeline with RAM latency 1:
  - A read issues at address a when the issue index is < N and the in-flight plus skid occupancy allows it.
  - The returned word lands in the output register, or in a 1-entry skid register if the output register is held.
  - The output register advances when !oValid or iFftReady.
  - Transfer occurs on oValid & iFftReady.
  - Order is strictly 0..N-1, with no duplicates or drops under any ready pattern.
  - oSop is high with sample 0; oEop is high with sample N-1.
  - After the transfer carrying oEop, go to WAITFFT. Maximum throughput is 1 sample/cycle.
- WAITFFT: iFftDone=1 increments oFrameCount and moves to HOLDOFF. iFftDone seen in any other state is ignored.
- HOLDOFF: count HOLDOFF_CYC cycles, then go to LOAD if iEnable=1, else IDLE.
- iEnable deasserted mid-frame: the current frame completes through WAITFFT; the next state is IDLE after HOLDOFF.
- iWindowSel changes are sampled only in LOAD, so a frame never mixes windows.
- oReadAddr holds its last value when no read is issued.
- Counters: issue and transfer indices are LBITS+1 bits wide so N is reachable without wrap. The hold-off and timeout counters are sized with $clog2.

Decomposition:
- Shared package audio_pkg:
  - state enum constants (S_IDLE..S_HOLDOFF)
  - window encodings WIN_HAMMING=0, WIN_HANN=1
  - default BITS/LBITS
- One natural sub-module, ram_read_stream: the address issuer, 1-cycle latency compensation, skid register and valid/ready output with SOP/EOP. The top holds the FSM and counters.

Test Plan:
- Basic frame (LBITS=4, HOLDOFF_CYC=8, RAM model data = address+100, iFftReady=1):
  - one oStartLoad pulse
  - 16 transfers of values 100..115 on consecutive cycles
  - oSop with 100, oEop with 115
  - iFftDone pulse -> oFrameCount=1
  - next oStartLoad exactly 8 cycles after HOLDOFF entry
- Backpressure: toggle iFftReady pseudo-randomly at 50% -> exactly 16 transfers, values 100..115 in order, oSample stable whenever oValid=1 and iFftReady=0.
- Load timeout (LOAD_TIMEOUT=20, iLoadComplete held 0) -> oLoadTimeout=1 at cycle 20 of WAITLOAD, state IDLE. The next oStartLoad clears the flag.
- Stale load-complete: iLoadComplete held 1 from the previous frame -> first WAITLOAD cycle is ignored; no STREAM before the second WAITLOAD cycle.
- Reset mid-STREAM, after 5 transfers -> all outputs 0 asynchronously. After release with iEnable=1, a fresh oStartLoad and the stream restart at value 100.
- Window latch: iWindowSel=1 at LOAD, switched to 0 during STREAM -> oWindow stays 1 for the frame and becomes 0 at the next LOAD. Also check oFrameCount wraps 255->0 after 256 frames.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio frame scheduler.
// States, window encodings and default geometry.
package audio_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAITLOAD,
    S_STREAM,
    S_WAITFFT,
    S_HOLDOFF
  } state_t;

  localparam logic WIN_HAMMING = 1'b0;
  localparam logic WIN_HANN    = 1'b1;

  localparam int DEF_BITS  = 16;
  localparam int DEF_LBITS = 10;

endpackage

// File: rtl/audio_frame_scheduler_if.sv
// RAM read port and FFT sample stream bundle.
// master = scheduler side, slave = RAM/FFT side.
interface audio_frame_scheduler_if #(
  parameter int BITS  = 16,
  parameter int LBITS = 10
);
  logic [LBITS-1:0] oReadAddr;
  logic [BITS-1:0]  iRamData;
  logic [BITS-1:0]  oSample;
  logic             oValid;
  logic             oSop;
  logic             oEop;
  logic             iFftReady;
  logic             iFftDone;

  modport master (
    output oReadAddr, oSample, oValid, oSop, oEop,
    input  iRamData, iFftReady, iFftDone
  );

  modport slave (
    input  oReadAddr, oSample, oValid, oSop, oEop,
    output iRamData, iFftReady, iFftDone
  );
endinterface

// File: rtl/ram_read_stream.sv
// Streams N RAM words in address order to a valid/ready sink.
// One-cycle RAM latency is absorbed by a single skid entry.
module ram_read_stream #(
  parameter int BITS  = 16,
  parameter int LBITS = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             ready,
  input  logic [BITS-1:0]  data,
  output logic [LBITS-1:0] addr,
  output logic [BITS-1:0]  sample,
  output logic             valid,
  output logic             sop,
  output logic             eop,
  output logic             last
);
  localparam logic [LBITS:0] NCNT  = {1'b1, {LBITS{1'b0}}};
  localparam logic [LBITS:0] NLAST = {1'b0, {LBITS{1'b1}}};

  logic [LBITS:0]   iss;
  logic [LBITS:0]   xcnt;
  logic [LBITS-1:0] addr_q;
  logic [BITS-1:0]  sk_d;
  logic             rd_v;
  logic             sk_v;
  logic             adv;
  logic             xfer;
  logic             sk_n;
  logic             issue;

  // A read may issue only if its data is sure to find room next cycle.
  always_comb begin
    adv   = !valid || ready;
    xfer  = valid && ready;
    sk_n  = rd_v ? (!adv || sk_v) : (sk_v && !adv);
    issue = run && (iss < NCNT) && !sk_n;
  end

  assign addr = issue ? iss[LBITS-1:0] : addr_q;
  assign sop  = valid && (xcnt == '0);
  assign eop  = valid && (xcnt == NLAST);
  assign last = xfer && (xcnt == NLAST);

  // Issue counter, in-flight flag, output register and skid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iss    <= '0;
      xcnt   <= '0;
      addr_q <= '0;
      sk_d   <= '0;
      sample <= '0;
      rd_v   <= 1'b0;
      sk_v   <= 1'b0;
      valid  <= 1'b0;
    end else if (!run) begin
      iss   <= '0;
      xcnt  <= '0;
      rd_v  <= 1'b0;
      sk_v  <= 1'b0;
      valid <= 1'b0;
    end else begin
      rd_v <= issue;
      if (issue) begin
        iss    <= iss + 1'b1;
        addr_q <= iss[LBITS-1:0];
      end
      if (xfer) xcnt <= xcnt + 1'b1;
      if (adv) begin
        if (sk_v) begin
          sample <= sk_d;
          valid  <= 1'b1;
        end else if (rd_v) begin
          sample <= data;
          valid  <= 1'b1;
        end else begin
          valid <= 1'b0;
        end
      end
      if (rd_v && (!adv || sk_v)) sk_d <= data;
      sk_v <= sk_n;
    end
  end
endmodule

// File: rtl/audio_frame_scheduler.sv
// Frame sequencer: load request, RAM-to-FFT stream, FFT wait
// and hold-off pacing, with a load-complete timeout.
module audio_frame_scheduler
  import audio_pkg::*;
#(
  parameter int BITS         = DEF_BITS,
  parameter int LBITS        = DEF_LBITS,
  parameter int HOLDOFF_CYC  = 50000,
  parameter int LOAD_TIMEOUT = 2000000
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iEnable,
  input  logic       iWindowSel,
  input  logic       iLoadComplete,
  output logic       oStartLoad,
  output logic       oWindow,
  output logic       oBusy,
  output logic [7:0] oFrameCount,
  output logic       oLoadTimeout,
  audio_frame_scheduler_if.master bus
);
  localparam int TW = $clog2(LOAD_TIMEOUT + 1);
  localparam int HW = $clog2(HOLDOFF_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(LOAD_TIMEOUT - 1);
  localparam logic [HW-1:0] HLAST = HW'(HOLDOFF_CYC - 1);

  state_t        state;
  logic [TW-1:0] tcnt;
  logic [HW-1:0] hcnt;
  logic          last;

  assign oBusy = (state != S_IDLE);

  ram_read_stream #(.BITS(BITS), .LBITS(LBITS)) u_stream (
    .clk    (iClock),
    .rst    (iReset),
    .run    (state == S_STREAM),
    .ready  (bus.iFftReady),
    .data   (bus.iRamData),
    .addr   (bus.oReadAddr),
    .sample (bus.oSample),
    .valid  (bus.oValid),
    .sop    (bus.oSop),
    .eop    (bus.oEop),
    .last   (last)
  );

  // Frame FSM; the load pulse is raised on the edge entering LOAD.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state        <= S_IDLE;
      oStartLoad   <= 1'b0;
      oWindow      <= WIN_HAMMING;
      oLoadTimeout <= 1'b0;
      oFrameCount  <= '0;
      tcnt         <= '0;
      hcnt         <= '0;
    end else begin
      oStartLoad <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (iEnable) begin
            state        <= S_LOAD;
            oStartLoad   <= 1'b1;
            oLoadTimeout <= 1'b0;
          end
        end
        S_LOAD: begin
          oWindow <= iWindowSel;
          tcnt    <= '0;
          state   <= S_WAITLOAD;
        end
        S_WAITLOAD: begin
          // tcnt==0 marks the first cycle, where a stale level may linger
          if (tcnt != '0 && iLoadComplete) begin
            state <= S_STREAM;
          end else if (tcnt == TLAST) begin
            oLoadTimeout <= 1'b1;
            state        <= S_IDLE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        S_STREAM: begin
          if (last) state <= S_WAITFFT;
        end
        S_WAITFFT: begin
          if (bus.iFftDone) begin
            oFrameCount <= oFrameCount + 1'b1;
            hcnt        <= '0;
            state       <= S_HOLDOFF;
          end
        end
        S_HOLDOFF: begin
          if (hcnt == HLAST) begin
            if (iEnable) begin
              state        <= S_LOAD;
              oStartLoad   <= 1'b1;
              oLoadTimeout <= 1'b0;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            hcnt <= hcnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
